// File: rtl/estufa_controlador.sv
// Greenhouse climate controller: per-zone debounced two-threshold sensor
// filter feeding an IDLE/HEAT/COOL/FAULT state machine with a minimum
// on-time for heaters and coolers and a latched inconsistency fault.
module estufa_controlador #(
  parameter int NZONES        = 4,
  parameter int FILT_CYCLES   = 4,
  parameter int MIN_ON_CYCLES = 8
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic [NZONES-1:0]     t1,
  input  logic [NZONES-1:0]     t2,
  input  logic                  fault_clr,
  output logic [NZONES-1:0]     heat,
  output logic [NZONES-1:0]     cool,
  output logic [NZONES-1:0]     fault,
  output logic                  fault_any,
  output logic [2*NZONES-1:0]   state
);

  localparam int CNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam int TMR_W = (MIN_ON_CYCLES > 1) ? $clog2(MIN_ON_CYCLES) : 1;

  // Counter value at which the current sample is the last one needed to qualify
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_QUAL = CNT_W'((FILT_CYCLES > 1) ? FILT_CYCLES - 2 : 0);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MIN_ON_CYCLES - 1);

  // Sensor codes as {t2,t1}
  localparam logic [1:0] CODE_COLD = 2'b00;
  localparam logic [1:0] CODE_BAD  = 2'b01;
  localparam logic [1:0] CODE_OK   = 2'b10;
  localparam logic [1:0] CODE_HOT  = 2'b11;

  // Zone FSM encoding, also exported on the state port
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_HEAT  = 2'b01;
  localparam logic [1:0] ST_COOL  = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  genvar z;
  generate
    for (z = 0; z < NZONES; z++) begin : g_zone
      logic [1:0]       raw;
      logic [1:0]       cand;
      logic [1:0]       filt;
      logic [CNT_W-1:0] cnt;
      logic [1:0]       st;
      logic [1:0]       st_next;
      logic [TMR_W-1:0] tmr;
      logic [TMR_W-1:0] tmr_next;

      assign raw = {t2[z], t1[z]};

      // Debounce: the filtered code only follows a raw code seen on FILT_CYCLES consecutive edges
      always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
          cand <= CODE_OK;
          cnt  <= '0;
          filt <= CODE_OK;
        end else if (raw != cand) begin
          cand <= raw;
          cnt  <= '0;
          if (FILT_CYCLES == 1) begin
            filt <= raw;
          end
        end else begin
          if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
          if ((FILT_CYCLES == 1) || (cnt == CNT_QUAL) || (cnt == CNT_MAX)) begin
            filt <= cand;
          end
        end
      end

      // Next-state and on-timer: HEAT/COOL always fall back through IDLE, faults win over the timer
      always_comb begin
        st_next  = st;
        tmr_next = '0;
        case (st)
          ST_IDLE: begin
            case (filt)
              CODE_COLD: begin
                st_next  = ST_HEAT;
                tmr_next = TMR_LOAD;
              end
              CODE_HOT: begin
                st_next  = ST_COOL;
                tmr_next = TMR_LOAD;
              end
              CODE_BAD: st_next = ST_FAULT;
              default:  st_next = ST_IDLE;
            endcase
          end
          ST_HEAT: begin
            if (filt == CODE_BAD) begin
              st_next = ST_FAULT;
            end else if ((filt != CODE_COLD) && (tmr == '0)) begin
              st_next = ST_IDLE;
            end else begin
              tmr_next = (tmr == '0) ? '0 : tmr - 1'b1;
            end
          end
          ST_COOL: begin
            if (filt == CODE_BAD) begin
              st_next = ST_FAULT;
            end else if ((filt != CODE_HOT) && (tmr == '0)) begin
              st_next = ST_IDLE;
            end else begin
              tmr_next = (tmr == '0) ? '0 : tmr - 1'b1;
            end
          end
          default: begin
            if (fault_clr && (filt != CODE_BAD)) begin
              st_next = ST_IDLE;
            end
          end
        endcase
      end

      // State and on-timer registers; reset clears outputs without waiting for a clock
      always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
          st  <= ST_IDLE;
          tmr <= '0;
        end else begin
          st  <= st_next;
          tmr <= tmr_next;
        end
      end

      assign heat[z]           = (st == ST_HEAT);
      assign cool[z]           = (st == ST_COOL);
      assign fault[z]          = (st == ST_FAULT);
      assign state[2*z+1:2*z]  = st;
    end
  endgenerate

  assign fault_any = |fault;

endmodule
